// File: rtl/vga_scan_controller.sv
// VGA raster generator and pixel compositor for the sprite renderers.
// Sync, blanking and colour are delay-matched to the renderer read latency before reaching the DAC pins.
module vga_scan_controller #(
    parameter int H_SYNC_WAIT   = 96,
    parameter int H_BACK_PORCH  = 48,
    parameter int H_ACTIVE      = 640,
    parameter int H_FRONT_PORCH = 16,
    parameter int V_SYNC_WAIT   = 2,
    parameter int V_BACK_PORCH  = 33,
    parameter int V_ACTIVE      = 480,
    parameter int V_FRONT_PORCH = 10,
    parameter int COLOR_DEPTH   = 9,
    parameter int PIPE_DELAY    = 1,
    parameter logic [COLOR_DEPTH-1:0] TRANSPARENT_KEY = 9'h1F8,
    parameter logic [COLOR_DEPTH-1:0] BG_COLOR        = 9'h049
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [9:0]             hcount,
    output logic [9:0]             vcount,
    output logic [9:0]             xcoord,
    output logic [9:0]             ycoord,
    output logic                   active,
    output logic                   frame_tick,
    input  logic [COLOR_DEPTH-1:0] color_in,
    input  logic                   sprite_hit,
    output logic [7:0]             vga_r,
    output logic [7:0]             vga_g,
    output logic [7:0]             vga_b,
    output logic                   vga_hs,
    output logic                   vga_vs,
    output logic                   vga_blank_n,
    output logic                   vga_sync_n
);

    localparam int H_TOTAL = H_SYNC_WAIT + H_BACK_PORCH + H_ACTIVE + H_FRONT_PORCH;
    localparam int V_TOTAL = V_SYNC_WAIT + V_BACK_PORCH + V_ACTIVE + V_FRONT_PORCH;
    localparam int H_START = H_SYNC_WAIT + H_BACK_PORCH;
    localparam int V_START = V_SYNC_WAIT + V_BACK_PORCH;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_BEGIN  = 10'(H_START);
    localparam logic [9:0] H_END    = 10'(H_START + H_ACTIVE);
    localparam logic [9:0] V_BEGIN  = 10'(V_START);
    localparam logic [9:0] V_END    = 10'(V_START + V_ACTIVE);
    localparam logic [9:0] H_SYNC_W = 10'(H_SYNC_WAIT);
    localparam logic [9:0] V_SYNC_W = 10'(V_SYNC_WAIT);

    logic       h_in, v_in;
    logic       hs_raw, vs_raw;
    logic [3:0] pipe [PIPE_DELAY];
    logic       hs_d, vs_d, act_d, hit_d;
    logic [COLOR_DEPTH-1:0] pixel;

    function automatic logic [7:0] expand(input logic [2:0] c);
        return {c, c, c[2:1]};
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcount <= '0;
            vcount <= '0;
        end else if (hcount == H_LAST) begin
            hcount <= '0;
            vcount <= (vcount == V_LAST) ? '0 : vcount + 10'd1;
        end else begin
            hcount <= hcount + 10'd1;
        end
    end

    always_comb begin
        h_in       = (hcount >= H_BEGIN) && (hcount < H_END);
        v_in       = (vcount >= V_BEGIN) && (vcount < V_END);
        active     = h_in && v_in;
        xcoord     = h_in ? hcount - H_BEGIN : '0;
        ycoord     = v_in ? vcount - V_BEGIN : '0;
        hs_raw     = hcount < H_SYNC_W;
        vs_raw     = vcount < V_SYNC_W;
        frame_tick = (hcount == H_LAST) && (vcount == V_LAST);
    end

    // Sync, blanking and hit travel alongside the renderer's ROM read so they meet color_in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PIPE_DELAY; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= {hs_raw, vs_raw, active, sprite_hit};
            for (int i = 1; i < PIPE_DELAY; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign {hs_d, vs_d, act_d, hit_d} = pipe[PIPE_DELAY-1];

    always_comb begin
        pixel = '0;
        if (act_d) pixel = (hit_d && color_in != TRANSPARENT_KEY) ? color_in : BG_COLOR;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
        end else begin
            vga_hs      <= ~hs_d;
            vga_vs      <= ~vs_d;
            vga_blank_n <= act_d;
            vga_r       <= expand(pixel[8:6]);
            vga_g       <= expand(pixel[5:3]);
            vga_b       <= expand(pixel[2:0]);
        end
    end

    assign vga_sync_n = 1'b0;

endmodule
